// File: rtl/poly_seq_pkg.sv
// Shared types, instruction layout and pitch/tempo helpers for the polyphonic note sequencer.
package poly_seq_pkg;

    localparam int unsigned TICK_W = 32;
    localparam int unsigned PER_W  = 24;

    localparam logic [3:0] OP_END = 4'b0000;
    localparam logic [3:0] OP_BPM = 4'b0001;

    typedef enum logic [1:0] {
        STY_NORMAL   = 2'd0,
        STY_LEGATO   = 2'd1,
        STY_STACCATO = 2'd2,
        STY_ALT      = 2'd3
    } style_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_DIV    = 3'd3,
        S_PLAY   = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // NOTE word layout, MSB first.
    typedef struct packed {
        logic       is_note;
        logic       chord;
        style_e     style;
        logic [3:0] len;
        logic [1:0] vol;
        logic [1:0] oct;
        logic [3:0] note;
    } note_instr_t;

    function automatic logic [TICK_W-1:0] default_tick(input int unsigned clk_hz,
                                                       input int unsigned bpm);
        return TICK_W'(clk_hz * 15 / bpm);
    endfunction

    // Octave-0 is C1..B1; frequencies in tenths of a hertz.
    function automatic logic [PER_W-1:0] period_tbl(input int unsigned clk_hz,
                                                    input logic [3:0] note);
        int unsigned f;
        case (note)
            4'd0:    f = 327;
            4'd1:    f = 346;
            4'd2:    f = 367;
            4'd3:    f = 389;
            4'd4:    f = 412;
            4'd5:    f = 437;
            4'd6:    f = 462;
            4'd7:    f = 490;
            4'd8:    f = 519;
            4'd9:    f = 550;
            4'd10:   f = 583;
            4'd11:   f = 617;
            default: f = 0;
        endcase
        if (f == 0) return PER_W'(1);
        return PER_W'(clk_hz * 10 / f);
    endfunction

endpackage

// File: rtl/seq_voice.sv
// One tone generator: sixteenth/tick length counters, phase counter with duty compare,
// and articulation gating. Loading restarts the voice from a clean state.
module seq_voice
    import poly_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [3:0]        i_note,
    input  logic [1:0]        i_oct,
    input  logic [1:0]        i_vol,
    input  logic [3:0]        i_len,
    input  style_e            i_style,
    input  logic [TICK_W-1:0] i_tick,
    output logic              o_out,
    output logic              o_busy
);

    logic              r_busy;
    logic              r_rest;
    logic [3:0]        r_len;
    logic [3:0]        r_six;
    style_e            r_style;
    logic [TICK_W-1:0] r_sub;
    logic [TICK_W-1:0] r_tick_l;
    logic [PER_W-1:0]  r_period;
    logic [PER_W-1:0]  r_high;
    logic [PER_W-1:0]  r_phase;

    logic [PER_W-1:0]  w_period;
    logic [PER_W-1:0]  w_high;
    logic              w_gate;

    assign w_period = period_tbl(CLK_HZ, i_note) >> i_oct;
    assign w_high   = (w_period >> 3) * (PER_W'(i_vol) + PER_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_rest   <= 1'b0;
            r_len    <= 4'd0;
            r_six    <= 4'd0;
            r_style  <= STY_NORMAL;
            r_sub    <= '0;
            r_tick_l <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_phase  <= '0;
        end else if (i_load) begin
            r_busy   <= 1'b1;
            r_rest   <= (i_note >= 4'd12);
            r_len    <= i_len;
            r_six    <= 4'd0;
            r_style  <= i_style;
            r_sub    <= '0;
            r_tick_l <= i_tick;
            r_period <= w_period;
            r_high   <= w_high;
            r_phase  <= '0;
        end else if (r_busy) begin
            r_phase <= (r_phase >= r_period - PER_W'(1)) ? '0 : r_phase + PER_W'(1);
            // Tempo is re-sampled only at sixteenth boundaries.
            if (r_sub + TICK_W'(1) >= r_tick_l) begin
                r_sub    <= '0;
                r_tick_l <= i_tick;
                if (r_six == r_len) r_busy <= 1'b0;
                else                r_six  <= r_six + 4'd1;
            end else begin
                r_sub <= r_sub + TICK_W'(1);
            end
        end
    end

    always_comb begin
        w_gate = 1'b1;
        case (r_style)
            STY_LEGATO:   w_gate = 1'b1;
            STY_STACCATO: w_gate = ({1'b0, r_six} < (({1'b0, r_len} + 5'd2) >> 1));
            default:      w_gate = !((r_len != 4'd0) && (r_six == r_len));
        endcase
    end

    assign o_out  = r_busy && !r_rest && w_gate && (r_phase < r_high);
    assign o_busy = r_busy;

endmodule

// File: rtl/poly_note_sequencer.sv
// Polyphonic music sequencer: fetches 16-bit instructions from async SRAM, decodes
// BPM/END/NOTE, divides tempo into a tick and drives VOICES tone generators.
module poly_note_sequencer
    import poly_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned VOICES      = 4,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned SRAM_WAIT   = 2,
    parameter int unsigned DEFAULT_BPM = 96
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic              SRAM_WE,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              SPEAKER,
    output logic [VOICES-1:0] VOICE_OUT,
    output logic              HALTED,
    output logic              ERR,
    output logic [ADDR_W-1:0] PC_DBG
);

    localparam int unsigned       VIDX_W   = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [VIDX_W-1:0] VMAX     = VIDX_W'(VOICES - 1);
    localparam logic [TICK_W-1:0] DIVIDEND = TICK_W'(CLK_HZ * 15);

    state_e            r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_sram_a;
    logic [7:0]        r_wait;
    logic [TICK_W-1:0] r_tick;
    logic [VIDX_W-1:0] r_vidx, r_last;
    logic              r_full, r_err;
    logic [11:0]       r_rem, r_div;
    logic [31:0]       r_quo;
    logic [4:0]        r_dcnt;

    note_instr_t       w_ni;
    logic [3:0]        w_op;
    logic [11:0]       w_bpm;
    logic [12:0]       w_trial;
    logic              w_ge;
    logic [VOICES-1:0] w_load, w_out, w_busy;
    logic              w_halted;

    assign w_ni    = note_instr_t'(SRAM_D);
    assign w_op    = SRAM_D[15:12];
    assign w_bpm   = SRAM_D[11:0];
    assign w_trial = {r_rem, r_quo[31]};
    assign w_ge    = (w_trial >= {1'b0, r_div});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   if (r_wait == 8'(SRAM_WAIT - 1)) w_next = S_DECODE;
            S_DECODE: begin
                if (w_ni.is_note)                          w_next = w_ni.chord ? S_FETCH : S_PLAY;
                else if (w_op == OP_END)                   w_next = S_HALT;
                else if (w_op == OP_BPM && w_bpm != 12'd0) w_next = S_DIV;
                else                                       w_next = S_FETCH;
            end
            S_DIV:    if (r_dcnt == 5'd31) w_next = S_FETCH;
            S_PLAY:   if (!w_busy[r_last]) w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_load   = '0;
        w_halted = (r_state == S_HALT);
        if (r_state == S_DECODE && w_ni.is_note) w_load[r_vidx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc     <= '0;
            r_sram_a <= '0;
            r_wait   <= 8'd0;
            r_tick   <= default_tick(CLK_HZ, DEFAULT_BPM);
            r_vidx   <= '0;
            r_last   <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
            r_rem    <= 12'd0;
            r_div    <= 12'd0;
            r_quo    <= 32'd0;
            r_dcnt   <= 5'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_sram_a <= r_pc;
                    r_wait   <= 8'd0;
                end
                S_WAIT: r_wait <= r_wait + 8'd1;
                S_DECODE: begin
                    r_pc <= r_pc + ADDR_W'(1);
                    if (w_ni.is_note) begin
                        // Once the top voice holds a chord member, any further note overwrites it.
                        if (r_full) r_err <= 1'b1;
                        if (w_ni.chord) begin
                            if (r_vidx == VMAX) r_full <= 1'b1;
                            else                r_vidx <= r_vidx + VIDX_W'(1);
                        end else begin
                            r_last <= r_vidx;
                            r_vidx <= '0;
                            r_full <= 1'b0;
                        end
                    end else if (w_op == OP_BPM) begin
                        if (w_bpm == 12'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_div  <= w_bpm;
                            r_quo  <= DIVIDEND;
                            r_rem  <= 12'd0;
                            r_dcnt <= 5'd0;
                        end
                    end else if (w_op != OP_END) begin
                        r_err <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_ge ? 12'(w_trial - {1'b0, r_div}) : w_trial[11:0];
                    r_quo  <= {r_quo[30:0], w_ge};
                    r_dcnt <= r_dcnt + 5'd1;
                    if (r_dcnt == 5'd31) r_tick <= {r_quo[30:0], w_ge};
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        seq_voice #(.CLK_HZ(CLK_HZ)) u_voice (
            .i_clk   (CLK),
            .i_rst_n (RST_N),
            .i_load  (w_load[g]),
            .i_note  (w_ni.note),
            .i_oct   (w_ni.oct),
            .i_vol   (w_ni.vol),
            .i_len   (w_ni.len),
            .i_style (w_ni.style),
            .i_tick  (r_tick),
            .o_out   (w_out[g]),
            .o_busy  (w_busy[g])
        );
    end

    assign SRAM_A    = r_sram_a;
    assign SRAM_WE   = 1'b1;
    assign SRAM_CE   = 1'b0;
    assign SRAM_OE   = 1'b0;
    assign SRAM_LB   = 1'b0;
    assign SRAM_UB   = 1'b0;
    assign VOICE_OUT = w_out;
    assign SPEAKER   = |w_out;
    assign HALTED    = w_halted;
    assign ERR       = r_err;
    assign PC_DBG    = r_pc;

endmodule

// File: tb/tb_poly_note_sequencer.sv
// Directed bench for poly_note_sequencer at CLK_HZ=1600, SRAM_WAIT=2, VOICES=4.
module tb_poly_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] sram_a, pc_dbg;
    logic [15:0] sram_d;
    logic        sram_we, sram_ce, sram_oe, sram_lb, sram_ub;
    logic        speaker, halted, err;
    logic [3:0]  voice_out;

    logic [15:0] mem [0:255];
    assign sram_d = (sram_a < 18'd256) ? mem[sram_a[7:0]] : 16'h0000;

    poly_note_sequencer #(
        .CLK_HZ(1600), .VOICES(4), .ADDR_W(18), .SRAM_WAIT(2), .DEFAULT_BPM(96)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .SRAM_A(sram_a), .SRAM_D(sram_d),
        .SRAM_WE(sram_we), .SRAM_CE(sram_ce), .SRAM_OE(sram_oe),
        .SRAM_LB(sram_lb), .SRAM_UB(sram_ub), .SPEAKER(speaker),
        .VOICE_OUT(voice_out), .HALTED(halted), .ERR(err), .PC_DBG(pc_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int c0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int first_hi [4];
    int last_hi  [4];
    int hi_cnt   [4];
    int chg      [16];
    int nchg, halt_k, err_k, mk;
    logic [17:0] prev_a;

    // Edge k after reset release is seen here as mk == k.
    always @(negedge clk) begin
        if (rst_n) begin
            mk = cyc - c0;
            for (int v = 0; v < 4; v++) begin
                if (voice_out[v]) begin
                    if (first_hi[v] < 0) first_hi[v] = mk;
                    last_hi[v] = mk;
                    hi_cnt[v]  = hi_cnt[v] + 1;
                end
            end
            if (sram_a != prev_a) begin
                if (nchg < 16) chg[nchg] = mk;
                nchg   = nchg + 1;
                prev_a = sram_a;
            end
            if (halted && halt_k < 0) halt_k = mk;
            if (err && err_k < 0)     err_k  = mk;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        for (int v = 0; v < 4; v++) begin
            first_hi[v] = -1;
            last_hi[v]  = -1;
            hi_cnt[v]   = 0;
        end
        for (int i = 0; i < 16; i++) chg[i] = -1;
        nchg   = 0;
        halt_k = -1;
        err_k  = -1;
        prev_a = 18'd0;
        repeat (2) @(negedge clk);
        c0    = cyc;
        rst_n = 1'b1;
    endtask

    task automatic wait_k(input int k);
        while ((cyc - c0) < k) @(negedge clk);
    endtask

    initial begin
        // Reset state
        clear_prog();
        restart();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_sram_a", sram_a, 0);
        chk("rst_pc", pc_dbg, 0);
        chk("rst_speaker", speaker, 0);
        chk("rst_voice_out", voice_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_sram_ctl", {sram_we, sram_ce, sram_oe, sram_lb, sram_ub}, 5'b10000);

        // BPM 60, legato note len3, END: tick 400, note 1600 cycles
        clear_prog();
        mem[0] = 16'h103C; mem[1] = 16'h93C0; mem[2] = 16'h0000;
        restart();
        wait_k(1700);
        chk("s1_fetch1_k", chg[0], 37);
        chk("s1_first_hi", first_hi[0], 40);
        chk("s1_last_hi", last_hi[0], 1639);
        chk("s1_hi_cnt", hi_cnt[0], 808);
        chk("s1_fetch2_k", chg[1], 1642);
        chk("s1_halt_k", halt_k, 1645);
        chk("s1_halted", halted, 1);
        chk("s1_pc", pc_dbg, 3);
        chk("s1_err", err, 0);
        chk("s1_v1_cnt", hi_cnt[1], 0);

        // Three-note chord then a plain note: allocation and vidx return to 0
        clear_prog();
        mem[0] = 16'hD0C0; mem[1] = 16'hD0C0; mem[2] = 16'h90C0;
        mem[3] = 16'h90C0; mem[4] = 16'h0000;
        restart();
        wait_k(560);
        chk("s2_fetch1_k", chg[0], 5);
        chk("s2_fetch2_k", chg[1], 9);
        chk("s2_v0_first", first_hi[0], 4);
        chk("s2_v1_first", first_hi[1], 8);
        chk("s2_v2_first", first_hi[2], 12);
        chk("s2_v2_last", last_hi[2], 261);
        chk("s2_fetch3_k", chg[2], 264);
        chk("s2_v0_last", last_hi[0], 516);
        chk("s2_v0_cnt", hi_cnt[0], 260);
        chk("s2_v3_cnt", hi_cnt[3], 0);
        chk("s2_halt_k", halt_k, 522);
        chk("s2_err", err, 0);

        // Five-note chord on four voices: overflow into voice 3
        clear_prog();
        mem[0] = 16'hD0C0; mem[1] = 16'hD0C0; mem[2] = 16'hD0C0;
        mem[3] = 16'hD0C0; mem[4] = 16'h90C9; mem[5] = 16'h0000;
        restart();
        wait_k(320);
        chk("s3_err", err, 1);
        chk("s3_err_k", err_k, 20);
        chk("s3_v3_cnt", hi_cnt[3], 112);
        chk("s3_v3_last", last_hi[3], 263);
        chk("s3_v0_cnt", hi_cnt[0], 130);
        chk("s3_v1_last", last_hi[1], 257);
        chk("s3_v2_last", last_hi[2], 261);
        chk("s3_fetch4_k", chg[3], 17);
        chk("s3_fetch5_k", chg[4], 272);

        // Invalid opcode then BPM 0: error, tick stays at 250
        clear_prog();
        mem[0] = 16'h2000; mem[1] = 16'h1000; mem[2] = 16'h90C0; mem[3] = 16'h0000;
        restart();
        wait_k(300);
        chk("s4_err_k", err_k, 4);
        chk("s4_fetch1_k", chg[0], 5);
        chk("s4_fetch2_k", chg[1], 9);
        chk("s4_v0_last", last_hi[0], 261);
        chk("s4_v0_cnt", hi_cnt[0], 130);
        chk("s4_pc", pc_dbg, 4);
        chk("s4_err", err, 1);

        // Staccato len3 at tick 400
        clear_prog();
        mem[0] = 16'h103C; mem[1] = 16'hA3C0; mem[2] = 16'h0000;
        restart();
        wait_k(1700);
        chk("s5_stac_cnt", hi_cnt[0], 408);
        chk("s5_stac_last", last_hi[0], 831);
        chk("s5_stac_play", chg[1], 1642);

        // Normal len3 at tick 400
        mem[1] = 16'h83C0;
        restart();
        wait_k(1700);
        chk("s5_norm_cnt", hi_cnt[0], 600);
        chk("s5_norm_last", last_hi[0], 1215);
        chk("s5_norm_play", chg[1], 1642);

        // Rest note len3: silent but occupies the full length
        mem[1] = 16'h83CC;
        restart();
        wait_k(1700);
        chk("s5_rest_cnt", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        chk("s5_rest_play", chg[1], 1642);
        chk("s5_rest_halt", halt_k, 1645);

        // Asynchronous reset mid-PLAY
        clear_prog();
        mem[0] = 16'h2000; mem[1] = 16'h103C; mem[2] = 16'h93C0; mem[3] = 16'h0000;
        restart();
        wait_k(284);
        chk("s6_pre_speaker", speaker, 1);
        chk("s6_pre_sram_a", sram_a, 2);
        chk("s6_pre_err", err, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_speaker", speaker, 0);
        chk("s6_rst_voice", voice_out, 0);
        chk("s6_rst_sram_a", sram_a, 0);
        chk("s6_rst_err", err, 0);
        chk("s6_rst_halted", halted, 0);
        restart();
        wait_k(30);
        chk("s6_refetch_k", chg[0], 5);
        chk("s6_refetch_err_k", err_k, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
